// File: rtl/add_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_seq_ctrl                                                 |
// | Description : Word-serial WORDS x W-bit adder built on one shared W-bit    |
// |               slice, LSW first, with valid/ready on both sides.            |
// |               Define ADD_SEQ_SUB_EN to add the 'sub' port (A - B mode).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module add_seq_ctrl #(
    parameter int WORDS = 4,
    parameter int W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORDS*W-1:0] a,
    input  logic [WORDS*W-1:0] b,
    input  logic               c_in,
`ifdef ADD_SEQ_SUB_EN
    input  logic               sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORDS*W-1:0] sum,
    output logic               c_out
);

    localparam int c_IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [WORDS*W-1:0] r_a;
    logic [WORDS*W-1:0] r_b;
    logic [WORDS*W-1:0] r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [W-1:0]       w_a_word;
    logic [W-1:0]       w_b_word;
    logic [W:0]         w_slice;
    logic               w_cin0;

`ifdef ADD_SEQ_SUB_EN
    logic               r_sub;

    // Subtraction is A + ~B + 1: invert every B word, seed the carry with 1.
    assign w_b_word = r_b[r_idx*W +: W] ^ {W{r_sub}};
    assign w_cin0   = sub ? 1'b1 : c_in;
`else
    assign w_b_word = r_b[r_idx*W +: W];
    assign w_cin0   = c_in;
`endif

    assign w_a_word = r_a[r_idx*W +: W];
    assign w_slice  = {1'b0, w_a_word} + {1'b0, w_b_word} + {{W{1'b0}}, r_carry};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= w_cin0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_RUN;
`ifdef ADD_SEQ_SUB_EN
                        r_sub      <= sub;
`endif
                    end
                end
                c_RUN: begin
                    r_sum[r_idx*W +: W] <= w_slice[W-1:0];
                    r_carry             <= w_slice[W];
                    // The index parks on the last word; it is cleared at the next handshake.
                    if (r_idx == c_LAST_IDX) begin
                        r_cout      <= w_slice[W];
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_cout;

endmodule
`default_nettype wire
